// File: rtl/dms_param_decoder_pkg.sv
// rtl/dms_param_decoder_pkg.sv - shared types, defaults and helpers for the duty-cycle decoder
package dms_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG_N,
        CFG_KEY,
        CFG_MASK,
        RUN
    } state_t;

    localparam int N_W_DEF         = 3;
    localparam int LOG_KEY_MAX_DEF = 5;
    localparam int CNT_W_DEF       = 16;
    localparam int MIN_PERIOD_DEF  = 2;
    localparam int KEY_MAX         = 1 << LOG_KEY_MAX_DEF;

    function automatic int unsigned key_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/dms_param_decoder_if.sv
// rtl/dms_param_decoder_if.sv - serial input / decoded output bundle of the decoder
interface dms_param_decoder_if;
    logic str;
    logic mode;
    logic msg;
    logic msg_valid;
    logic frame;
    logic configured;
    logic cfg_err;

    modport master (
        output str, mode,
        input  msg, msg_valid, frame, configured, cfg_err
    );

    modport slave (
        input  str, mode,
        output msg, msg_valid, frame, configured, cfg_err
    );
endinterface

// File: rtl/dms_param_decoder_period_meter.sv
// rtl/dms_param_decoder_period_meter.sv - measures high/low cycles between rising edges of str
module dms_period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             str,
    input  logic             enable,
    output logic             boundary,
    output logic             first_edge,
    output logic [CNT_W-1:0] ones,
    output logic [CNT_W-1:0] zeros
);
    logic prev;

    assign boundary = enable && !prev && str;

    // Outside run mode the meter is held cleared so the next run starts fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= 1'b0;
            ones       <= '0;
            zeros      <= '0;
            first_edge <= 1'b1;
        end else if (!enable) begin
            ones       <= '0;
            zeros      <= '0;
            first_edge <= 1'b1;
        end else begin
            prev <= str;
            if (boundary) begin
                first_edge <= 1'b0;
                ones       <= CNT_W'(1);
                zeros      <= '0;
            end else if (str) begin
                if (ones != '1) ones <= ones + CNT_W'(1);
            end else begin
                if (zeros != '1) zeros <= zeros + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/dms_param_decoder.sv
// rtl/dms_param_decoder.sv - serially configured, keyed and masked duty-cycle symbol decoder
module dms_param_decoder
    import dms_pkg::*;
#(
    parameter int N_W         = N_W_DEF,
    parameter int LOG_KEY_MAX = LOG_KEY_MAX_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MIN_PERIOD  = MIN_PERIOD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    dms_param_decoder_if.slave  dms
);
    localparam int KMAX = 1 << LOG_KEY_MAX;
    localparam int CW   = LOG_KEY_MAX + 1;
    localparam int IW   = LOG_KEY_MAX;
    localparam int SW   = CNT_W + 1;

    state_t            state, state_nxt;
    logic [N_W-2:0]    n_sh;
    logic [N_W-1:0]    n, n_final;
    logic [CW-1:0]     cnt, last_pos;
    logic [KMAX-1:0]   key, mask;
    logic [IW-1:0]     idx;
    logic              start_cfg, n_done, key_done, mask_done;
    logic              run_en, boundary, first_edge, emit, sym;
    logic [CNT_W-1:0]  ones, zeros;
    logic [SW-1:0]     sum;

    assign n_final  = {n_sh, dms.str};
    assign last_pos = CW'(key_len(32'(n)) - 32'd1);
    assign run_en   = (state == RUN) && !dms.mode;
    assign sum      = SW'(ones) + SW'(zeros);
    assign sym      = ones > zeros;
    assign emit     = boundary && !first_edge && (sum >= SW'(MIN_PERIOD));

    dms_period_meter #(.CNT_W(CNT_W)) u_meter (
        .clk        (clk),
        .reset      (reset),
        .str        (dms.str),
        .enable     (run_en),
        .boundary   (boundary),
        .first_edge (first_edge),
        .ones       (ones),
        .zeros      (zeros)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_cfg = 1'b0;
        n_done    = 1'b0;
        key_done  = 1'b0;
        mask_done = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (dms.mode) begin
                    state_nxt = CFG_N;
                    start_cfg = 1'b1;
                end
            end
            CFG_N: begin
                if (!dms.mode) state_nxt = IDLE;
                else if (cnt == CW'(N_W - 1)) begin
                    n_done    = 1'b1;
                    state_nxt = CFG_KEY;
                end
            end
            CFG_KEY: begin
                if (!dms.mode) state_nxt = IDLE;
                else if (cnt == last_pos) begin
                    key_done  = 1'b1;
                    state_nxt = CFG_MASK;
                end
            end
            CFG_MASK: begin
                if (!dms.mode) state_nxt = IDLE;
                else if (cnt == last_pos) begin
                    mask_done = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_sh           <= '0;
            n              <= '0;
            cnt            <= '0;
            key            <= '0;
            mask           <= '0;
            idx            <= '0;
            dms.msg        <= 1'b0;
            dms.msg_valid  <= 1'b0;
            dms.frame      <= 1'b0;
            dms.configured <= 1'b0;
            dms.cfg_err    <= 1'b0;
        end else begin
            dms.msg_valid <= 1'b0;
            dms.frame     <= 1'b0;
            if (start_cfg) begin
                n_sh           <= (N_W - 1)'(dms.str);
                cnt            <= CW'(1);
                dms.configured <= 1'b0;
                dms.cfg_err    <= 1'b0;
            end else if (run_en && emit) begin
                dms.msg       <= (sym ^ key[idx]) | mask[idx];
                dms.msg_valid <= 1'b1;
                dms.frame     <= (idx == '0);
                idx           <= ({1'b0, idx} == last_pos) ? '0 : idx + IW'(1);
            end else if (dms.mode) begin
                case (state)
                    CFG_N: begin
                        n_sh <= n_final[N_W-2:0];
                        cnt  <= n_done ? '0 : cnt + CW'(1);
                        if (n_done) begin
                            // Oversized n is reported and clamped to the storage limit.
                            if (32'(n_final) > LOG_KEY_MAX) begin
                                dms.cfg_err <= 1'b1;
                                n           <= N_W'(LOG_KEY_MAX);
                            end else begin
                                n <= n_final;
                            end
                        end
                    end
                    CFG_KEY: begin
                        key[cnt[IW-1:0]] <= dms.str;
                        cnt <= key_done ? '0 : cnt + CW'(1);
                    end
                    CFG_MASK: begin
                        mask[cnt[IW-1:0]] <= dms.str;
                        cnt <= mask_done ? '0 : cnt + CW'(1);
                        if (mask_done) begin
                            dms.configured <= 1'b1;
                            idx            <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dms_param_decoder.sv
// tb/tb_dms_param_decoder.sv - randomized period-level model check of dms_param_decoder
module tb_dms_param_decoder;
    import dms_pkg::*;

    localparam int NW   = 3;
    localparam int LKM  = 5;
    localparam int CNTW = 4;
    localparam int MINP = 3;
    localparam int SAT  = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dms_param_decoder_if dif();

    dms_param_decoder #(
        .N_W(NW), .LOG_KEY_MAX(LKM), .CNT_W(CNTW), .MIN_PERIOD(MINP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dms   (dif)
    );

    int checks = 0;
    int errors = 0;

    bit [31:0] key_m, mask_m;
    int        len_m, idx_m;
    bit        last_msg, exp_v, exp_m, exp_f;
    int        hs_q[$];
    int        ls_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 unit after the edge.
    task automatic step(input bit s, input bit m);
        dif.str  = s;
        dif.mode = m;
        @(posedge clk);
        #1;
        check("msg_valid", dif.msg_valid, exp_v);
        check("frame", dif.frame, exp_v ? exp_f : 1'b0);
        if (exp_v) begin
            check("msg", dif.msg, exp_m);
            last_msg = exp_m;
        end else begin
            check("msg_hold", dif.msg, last_msg);
        end
        exp_v = 1'b0;
    endtask

    // Decision for a completed period of h high and l low cycles.
    task automatic predict(input int h, input int l);
        int sh, sl;
        bit s;
        sh = (h > SAT) ? SAT : h;
        sl = (l > SAT) ? SAT : l;
        if (sh + sl >= MINP) begin
            s     = sh > sl;
            exp_v = 1'b1;
            exp_m = (s ^ key_m[idx_m]) | mask_m[idx_m];
            exp_f = (idx_m == 0);
            idx_m = (idx_m + 1) % len_m;
        end
    endtask

    task automatic configure(input int n, input bit [31:0] kv, input bit [31:0] mv);
        int nn;
        nn    = (n > LKM) ? LKM : n;
        len_m = 1 << nn;
        for (int i = NW - 1; i >= 0; i--) begin
            step(1'((n >> i) & 1), 1'b1);
            if (i == NW - 1) check("configured_start", dif.configured, 0);
        end
        for (int k = 0; k < len_m; k++) begin
            key_m[k] = kv[k];
            step(kv[k], 1'b1);
        end
        for (int k = 0; k < len_m; k++) begin
            mask_m[k] = mv[k];
            if (k == len_m - 1) check("configured_mid", dif.configured, 0);
            step(mv[k], 1'b1);
        end
        check("configured", dif.configured, 1);
        check("cfg_err", dif.cfg_err, (n > LKM) ? 1 : 0);
        idx_m = 0;
    endtask

    task automatic run_periods();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int p = 0; p < hs_q.size(); p++) begin
            if (p > 0) predict(hs_q[p-1], ls_q[p-1]);
            for (int c = 0; c < hs_q[p]; c++) step(1'b1, 1'b0);
            for (int c = 0; c < ls_q[p]; c++) step(1'b0, 1'b0);
        end
        predict(hs_q[hs_q.size()-1], ls_q[ls_q.size()-1]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic fill_random(input int np);
        hs_q.delete();
        ls_q.delete();
        for (int p = 0; p < np; p++) begin
            if ($urandom_range(0, 5) == 0) begin
                hs_q.push_back(1);
                ls_q.push_back(1);
            end else begin
                hs_q.push_back($urandom_range(1, 20));
                ls_q.push_back($urandom_range(1, 20));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_msg"}, dif.msg, 0);
        check({tag, "_msg_valid"}, dif.msg_valid, 0);
        check({tag, "_frame"}, dif.frame, 0);
        check({tag, "_configured"}, dif.configured, 0);
        check({tag, "_cfg_err"}, dif.cfg_err, 0);
    endtask

    initial begin
        reset    = 1'b1;
        dif.str  = 1'b0;
        dif.mode = 1'b0;
        exp_v    = 1'b0;
        last_msg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Directed: n=2, key 1,0,1,0, mask 0,0,0,1, five high3/low1 symbols.
        configure(2, 32'b0101, 32'b1000);
        hs_q = '{3, 3, 3, 3, 3};
        ls_q = '{1, 1, 1, 1, 1};
        run_periods();

        // Tie, glitch, then a normal symbol.
        configure(2, 32'b0101, 32'b1000);
        hs_q = '{2, 1, 3, 2};
        ls_q = '{2, 1, 1, 3};
        run_periods();

        // Long periods that would decode wrongly if a counter wrapped.
        configure(2, 32'b0101, 32'b0000);
        hs_q = '{40, 2, 16, 17, 5};
        ls_q = '{2, 33, 5, 3, 31};
        run_periods();

        // Oversized n: clamped to 32-bit key/mask, idx wraps past 32.
        configure(7, $urandom(), $urandom());
        fill_random(40);
        run_periods();

        for (int it = 0; it < 5; it++) begin
            configure($urandom_range(0, LKM), $urandom(), $urandom());
            fill_random(14);
            run_periods();
        end

        // Reset in the middle of a run.
        configure(1, $urandom(), $urandom());
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrun_reset");
        reset    = 1'b0;
        last_msg = 1'b0;
        for (int i = 0; i < 6; i++) step(1'(i & 1), 1'b0);
        check("idle_configured", dif.configured, 0);

        // Abort two bits into the key, then stay idle.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("abort_configured", dif.configured, 0);
        for (int i = 0; i < 8; i++) step(1'((i >> 1) & 1), 1'b0);
        check("abort_idle_configured", dif.configured, 0);

        configure(3, $urandom(), $urandom());
        fill_random(12);
        run_periods();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dms_param_decoder.md
Name: dms_param_decoder

Overview:
- Parametrised successor to the serial decryption message block; configured by a serial bitstream, then decodes a duty-cycle-encoded stream on `str`.
- Run mode measures each symbol period between rising edges of `str`. A period with more high than low cycles decodes as 1, otherwise 0.
- Each decoded bit is combined with a per-position key bit and mask bit: msg = (s ^ key[idx]) | mask[idx].
- Adds a key length of up to KEY_MAX, valid and frame handshake outputs, glitch rejection, counter saturation and config error reporting.

Parameters:
- N_W, 3: width of serial config field n; key length L = 2^n.
- LOG_KEY_MAX, 5: largest legal n; key/mask storage KEY_MAX = 2^LOG_KEY_MAX bits (32).
- CNT_W, 16: width of high/low duty counters.
- MIN_PERIOD, 2: periods shorter than this many cycles are rejected as glitches.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- str  in  1  serial data: config bits when mode=1, encoded symbols when mode=0.
- mode  in  1  1 = configure, 0 = run.
- msg  out  1  decoded, keyed, masked output bit; holds its value between valid pulses.
- msg_valid  out  1  one-cycle pulse when `msg` is updated.
- frame  out  1  asserted together with msg_valid when idx==0, i.e. the first bit of each L-bit group.
- configured  out  1  high once a full config stream has been loaded.
- cfg_err  out  1  sticky; set when the loaded n > LOG_KEY_MAX; cleared by reset or a new config.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - n, key, mask, idx, counters and the prev register all 0.
  - The first_edge flag is set.
- States: IDLE, CFG_N, CFG_KEY, CFG_MASK, RUN.
- IDLE:
  - mode=1 moves to CFG_N; the current str bit is taken as the first n bit, MSB first.
  - mode=0 stays in IDLE.
- CFG_N:
  - Shifts in N_W bits, MSB first.
  - If the final value exceeds LOG_KEY_MAX, set cfg_err and clamp n to LOG_KEY_MAX.
  - Then move to CFG_KEY.
- CFG_KEY: shifts L bits; the k-th bit received is stored at key[k], so the first bit goes to key[0].
- CFG_MASK:
  - Shifts L bits the same way into mask.
  - On the last bit: configured <= 1, idx <= 0, first_edge <= 1, and move to RUN.
- Config counter widths: the count is zero-extended to LOG_KEY_MAX+1 bits.
- Config abort:
  - mode=0 during any CFG_* state returns to IDLE with configured=0.
  - Partial key/mask contents are don't-care.
- RUN, when mode=0, each cycle:
  - prev <= str.
  - A boundary is prev==0 && str==1.
  - Non-boundary cycle: increment ones if str=1, else increment zeros. Both counters saturate at 2^CNT_W-1 and do not wrap.
  - Boundary cycle:
    - If first_edge is set: clear it and emit nothing.
    - Otherwise, if ones+zeros >= MIN_PERIOD: s = (ones > zeros), where a tie decodes as 0. Register msg = (s ^ key[idx]) | mask[idx], pulse msg_valid, set frame = (idx==0), and advance idx with wrap L-1 -> 0.
    - If ones+zeros < MIN_PERIOD: this is a glitch. No pulse, idx unchanged.
    - In all cases the new period starts with ones=1, zeros=0.
- Latency: msg/msg_valid/frame are registered and appear the cycle after the boundary sample.
- mode=1 in RUN:
  - Restarts configuration at CFG_N, consuming that cycle's str bit.
  - configured <= 0, cfg_err <= 0, counters cleared; no valid pulse is generated.
- Reset mid-operation: takes priority over everything and returns to the reset values above.
- The sum ones+zeros is computed at CNT_W+1 bits, so it never overflows.

Decomposition:
- Package dms_pkg holds:
  - the state enum;
  - the N_W, LOG_KEY_MAX and CNT_W defaults;
  - the localparam KEY_MAX;
  - the function key_len(n) = 1 << n.
- One sub-module, dms_period_meter:
  - Inputs: clk, reset, str, enable.
  - Outputs: boundary pulse, first-edge suppression, saturated ones/zeros at the boundary.
  - The top level holds the FSM, the key/mask registers and the output register.

Test Plan:
- Config n=2 (bits 010), key bits 1,0,1,0, mask bits 0,0,0,1: 11 cycles with mode=1 -> configured=1 after the 11th bit, cfg_err=0.
- Run with that config. One lead-in boundary, then periods high3/low1 (s=1) ×4 -> msg = 0,1,0,1 (the last is forced by the mask). frame=1 only on the 1st pulse; frame again on the 5th decoded bit as idx wraps.
- Tie and glitch:
  - A period of high2/low2 decodes s=0, giving msg = key[idx].
  - A period of 1 high cycle followed by a rising edge (length 1 < MIN_PERIOD) produces no msg_valid and leaves idx unchanged.
- Saturation: CNT_W=4 with a 40-cycle high / 2-cycle low period -> ones saturates at 15 and s=1 is emitted; the counter shows no wraparound.
- Illegal config: n bits 111 with LOG_KEY_MAX=5 -> cfg_err=1, n clamped to 5, 32 key and 32 mask bits expected.
- Reset asserted mid-RUN, and mode=0 two bits into CFG_KEY -> respectively all outputs 0 and IDLE next cycle; configured=0 with no valid pulses.
